// File: rtl/bus_arbiter_rr.sv
// Arbitrates NUM_MST masters onto the single QSPI memory port, fixed or round-robin priority.
// Latency: winner registered in IDLE, slave command pulses the next cycle, completion routed back combinationally.
// Backpressure: one transaction in flight; masters hold level requests until their own completion strobe.
module bus_arbiter_rr #(
  parameter int NUM_MST  = 4,
  parameter int ADR_W    = 32,
  parameter int DAT_W    = 32,
  parameter int ARB_MODE = 1,
  parameter int TMO_CYC  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_MST-1:0]       m_read_req,
  input  logic [NUM_MST-1:0]       m_read_w,
  input  logic [NUM_MST-1:0]       m_read_hw,
  input  logic [NUM_MST*ADR_W-1:0] m_read_adr,
  input  logic [NUM_MST-1:0]       m_write_req,
  input  logic [NUM_MST-1:0]       m_write_w,
  input  logic [NUM_MST-1:0]       m_write_hw,
  input  logic [NUM_MST*ADR_W-1:0] m_write_adr,
  input  logic [NUM_MST*DAT_W-1:0] m_write_data,
  output logic [NUM_MST-1:0]       m_read_valid,
  output logic [NUM_MST-1:0]       m_write_finish,
  output logic [NUM_MST-1:0]       m_bus_err,
  output logic                     read_req,
  output logic                     read_w,
  output logic                     read_hw,
  output logic [ADR_W-1:0]         read_adr,
  output logic                     write_req,
  output logic                     write_w,
  output logic                     write_hw,
  output logic [ADR_W-1:0]         write_adr,
  output logic [DAT_W-1:0]         write_data,
  input  logic                     read_valid,
  input  logic                     write_finish,
  output logic [2:0]               grant_id,
  output logic                     busy,
  output logic                     tmo_flag
);

  // Per-master views are padded to 8 entries so a 3-bit index is always in range.
  localparam int MAXM = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t           state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic             is_wr_q, is_wr_d;
  logic             sz_w_q, sz_w_d;
  logic             sz_hw_q, sz_hw_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [DAT_W-1:0] dat_q, dat_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             tmo_flag_q, tmo_flag_d;

  logic [MAXM-1:0]  rreq_a, rw_a, rhw_a, wreq_a, ww_a, whw_a;
  logic [ADR_W-1:0] radr_a [MAXM];
  logic [ADR_W-1:0] wadr_a [MAXM];
  logic [DAT_W-1:0] wdat_a [MAXM];

  assign rreq_a = MAXM'(m_read_req);
  assign rw_a   = MAXM'(m_read_w);
  assign rhw_a  = MAXM'(m_read_hw);
  assign wreq_a = MAXM'(m_write_req);
  assign ww_a   = MAXM'(m_write_w);
  assign whw_a  = MAXM'(m_write_hw);

  for (genvar i = 0; i < MAXM; i++) begin : g_unpack
    if (i < NUM_MST) begin : g_used
      assign radr_a[i] = m_read_adr[i*ADR_W +: ADR_W];
      assign wadr_a[i] = m_write_adr[i*ADR_W +: ADR_W];
      assign wdat_a[i] = m_write_data[i*DAT_W +: DAT_W];
    end else begin : g_pad
      assign radr_a[i] = '0;
      assign wadr_a[i] = '0;
      assign wdat_a[i] = '0;
    end
  end

  logic       found;
  logic [2:0] win;
  logic [3:0] idx;

  // Winner search: from the RR pointer with wrap in round-robin mode, from index 0 in fixed mode.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_MST; k++) begin
      if (ARB_MODE == 1) idx = {1'b0, ptr_q} + 4'(k);
      else               idx = 4'(k);
      if (idx >= 4'(NUM_MST)) idx = idx - 4'(NUM_MST);
      if (!found && (rreq_a[idx[2:0]] || wreq_a[idx[2:0]])) begin
        found = 1'b1;
        win   = idx[2:0];
      end
    end
  end

  logic in_txn, done_hit, tmo_hit, finish_any;
  logic [NUM_MST-1:0] owner_oh;

  // Only the strobe matching the pending type counts; a real completion beats a same-cycle timeout.
  assign in_txn     = (state_q != ST_IDLE);
  assign done_hit   = in_txn && (is_wr_q ? write_finish : read_valid);
  assign tmo_hit    = (TMO_CYC != 0) && in_txn && !done_hit && (cnt_q == 16'(TMO_CYC));
  assign finish_any = done_hit || tmo_hit;
  assign owner_oh   = {{(NUM_MST-1){1'b0}}, 1'b1} << grant_q;

  // Next-state logic: latch the winner's command in IDLE, hold it through ISSUE/WAIT.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    is_wr_d    = is_wr_q;
    sz_w_d     = sz_w_q;
    sz_hw_d    = sz_hw_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    ptr_d      = ptr_q;
    cnt_d      = '0;
    tmo_flag_d = tmo_flag_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_ISSUE;
          grant_d = win;
          is_wr_d = wreq_a[win];
          if (wreq_a[win]) begin
            sz_w_d  = ww_a[win];
            sz_hw_d = whw_a[win];
            adr_d   = wadr_a[win];
            dat_d   = wdat_a[win];
          end else begin
            sz_w_d  = rw_a[win];
            sz_hw_d = rhw_a[win];
            adr_d   = radr_a[win];
            dat_d   = '0;
          end
          if (ARB_MODE == 1) ptr_d = (win == 3'(NUM_MST-1)) ? 3'd0 : win + 3'd1;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        state_d = ST_WAIT;
        if (TMO_CYC != 0) cnt_d = cnt_q + 16'd1;
        if (finish_any) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
        if (tmo_hit) tmo_flag_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and command registers; reset drops everything including any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      is_wr_q    <= 1'b0;
      sz_w_q     <= 1'b0;
      sz_hw_q    <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      is_wr_q    <= is_wr_d;
      sz_w_q     <= sz_w_d;
      sz_hw_q    <= sz_hw_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  assign busy       = in_txn;
  assign grant_id   = grant_q;
  assign tmo_flag   = tmo_flag_q;

  assign read_req   = (state_q == ST_ISSUE) && !is_wr_q;
  assign read_w     = !is_wr_q && sz_w_q;
  assign read_hw    = !is_wr_q && sz_hw_q;
  assign read_adr   = is_wr_q ? '0 : adr_q;

  assign write_req  = (state_q == ST_ISSUE) && is_wr_q;
  assign write_w    = is_wr_q && sz_w_q;
  assign write_hw   = is_wr_q && sz_hw_q;
  assign write_adr  = is_wr_q ? adr_q : '0;
  assign write_data = is_wr_q ? dat_q : '0;

  assign m_read_valid   = (!is_wr_q && finish_any) ? owner_oh : '0;
  assign m_write_finish = ( is_wr_q && finish_any) ? owner_oh : '0;
  assign m_bus_err      = tmo_hit ? owner_oh : '0;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: round-robin DUT with an 8-cycle watchdog plus a fixed-priority DUT.
// Stimulus pushes expected slave commands and completions; negedge monitors pop and compare.
// Masters and slave are modelled behaviourally and react one ns after each rising edge.
module tb_bus_arbiter_rr;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Round-robin DUT signals
  logic [N-1:0]    m_read_req, m_read_w, m_read_hw, m_write_req, m_write_w, m_write_hw;
  logic [N*32-1:0] m_read_adr, m_write_adr, m_write_data;
  logic [N-1:0]    m_read_valid, m_write_finish, m_bus_err;
  logic            read_req, read_w, read_hw, write_req, write_w, write_hw;
  logic [31:0]     read_adr, write_adr, write_data;
  logic            read_valid, write_finish;
  logic [2:0]      grant_id;
  logic            busy, tmo_flag;

  // Fixed-priority DUT signals
  logic [N-1:0]    fx_rreq, fx_zero;
  logic [N*32-1:0] fx_zadr;
  logic [N-1:0]    fx_m_rv, fx_m_wf, fx_m_err;
  logic            fx_read_req, fx_read_w, fx_read_hw, fx_write_req, fx_write_w, fx_write_hw;
  logic [31:0]     fx_read_adr, fx_write_adr, fx_write_data;
  logic            fx_read_valid, fx_write_finish;
  logic [2:0]      fx_grant;
  logic            fx_busy, fx_tmo;

  bus_arbiter_rr #(.NUM_MST(N), .ADR_W(32), .DAT_W(32), .ARB_MODE(1), .TMO_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_read_req(m_read_req), .m_read_w(m_read_w), .m_read_hw(m_read_hw), .m_read_adr(m_read_adr),
    .m_write_req(m_write_req), .m_write_w(m_write_w), .m_write_hw(m_write_hw),
    .m_write_adr(m_write_adr), .m_write_data(m_write_data),
    .m_read_valid(m_read_valid), .m_write_finish(m_write_finish), .m_bus_err(m_bus_err),
    .read_req(read_req), .read_w(read_w), .read_hw(read_hw), .read_adr(read_adr),
    .write_req(write_req), .write_w(write_w), .write_hw(write_hw), .write_adr(write_adr),
    .write_data(write_data), .read_valid(read_valid), .write_finish(write_finish),
    .grant_id(grant_id), .busy(busy), .tmo_flag(tmo_flag)
  );

  bus_arbiter_rr #(.NUM_MST(N), .ADR_W(32), .DAT_W(32), .ARB_MODE(0), .TMO_CYC(0)) dut_fx (
    .clk(clk), .rst_n(rst_n),
    .m_read_req(fx_rreq), .m_read_w(fx_zero), .m_read_hw(fx_zero), .m_read_adr(fx_zadr),
    .m_write_req(fx_zero), .m_write_w(fx_zero), .m_write_hw(fx_zero),
    .m_write_adr(fx_zadr), .m_write_data(fx_zadr),
    .m_read_valid(fx_m_rv), .m_write_finish(fx_m_wf), .m_bus_err(fx_m_err),
    .read_req(fx_read_req), .read_w(fx_read_w), .read_hw(fx_read_hw), .read_adr(fx_read_adr),
    .write_req(fx_write_req), .write_w(fx_write_w), .write_hw(fx_write_hw), .write_adr(fx_write_adr),
    .write_data(fx_write_data), .read_valid(fx_read_valid), .write_finish(fx_write_finish),
    .grant_id(fx_grant), .busy(fx_busy), .tmo_flag(fx_tmo)
  );

  typedef struct { logic [2:0] gid; logic wr; logic w; logic hw; logic [31:0] adr; logic [31:0] dat; } cmd_t;
  typedef struct { logic [3:0] rv; logic [3:0] wf; logic [3:0] be; int dly; } cpl_t;

  cmd_t       cmd_q[$];
  cpl_t       cpl_q[$];
  logic [2:0] fx_q[$];
  cmd_t       cur, ecmd;
  cpl_t       ecpl;
  logic [2:0] efx;

  int n_chk = 0, n_pass = 0, cyc = 0, cmd_cyc = 0, cmd_seen = 0, fx_seen = 0;
  bit stab_bad = 1'b0;
  int rd_reps[N], wr_reps[N];
  bit rd_done[N], wr_done[N];
  int lat = 2, mute = 0, rd_cnt = 0, wr_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic logic [97:0] out_fields(input logic wr);
    return wr ? {write_w, write_hw, write_adr, write_data} : {read_w, read_hw, read_adr, 32'h0};
  endfunction

  function automatic logic [97:0] exp_fields(input cmd_t e);
    return {e.w, e.hw, e.adr, e.wr ? e.dat : 32'h0};
  endfunction

  task automatic push_cmd(input logic [2:0] gid, input logic wr, input logic w, input logic hw,
                          input logic [31:0] adr, input logic [31:0] dat);
    cmd_t c;
    c.gid = gid; c.wr = wr; c.w = w; c.hw = hw; c.adr = adr; c.dat = dat;
    cmd_q.push_back(c);
  endtask

  task automatic push_cpl(input logic [3:0] rv, input logic [3:0] wf, input logic [3:0] be, input int dly);
    cpl_t c;
    c.rv = rv; c.wf = wf; c.be = be; c.dly = dly;
    cpl_q.push_back(c);
  endtask

  task automatic rd(input int i, input logic [31:0] adr, input logic w, input logic hw, input int reps);
    m_read_adr[i*32 +: 32] = adr;
    m_read_w[i] = w; m_read_hw[i] = hw;
    rd_reps[i] = reps; m_read_req[i] = 1'b1;
  endtask

  task automatic wr(input int i, input logic [31:0] adr, input logic [31:0] dat, input logic w,
                    input logic hw, input int reps);
    m_write_adr[i*32 +: 32] = adr; m_write_data[i*32 +: 32] = dat;
    m_write_w[i] = w; m_write_hw[i] = hw;
    wr_reps[i] = reps; m_write_req[i] = 1'b1;
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #2;
      if (cmd_q.size() == 0 && cpl_q.size() == 0 && m_read_req == '0 && m_write_req == '0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1'b1);
  endtask

  // Cycle counter used for completion latency.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor for the round-robin DUT: slave commands, completions, and command stability.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (read_req || write_req) begin
        cmd_seen++;
        if (cmd_q.size() == 0) begin
          n_chk++;
          $display("FAIL cmd_unexpected: grant %0d issued, none required", grant_id);
        end else begin
          ecmd = cmd_q.pop_front();
          check("cmd_gid", grant_id, ecmd.gid);
          check("cmd_type", {read_req, write_req}, ecmd.wr ? 2'b01 : 2'b10);
          check("cmd_fields", out_fields(ecmd.wr), exp_fields(ecmd));
        end
        cur = ecmd; cmd_cyc = cyc; stab_bad = 1'b0;
      end else if (busy && out_fields(cur.wr) !== exp_fields(cur)) begin
        stab_bad = 1'b1;
      end
      if (m_read_valid != '0 || m_write_finish != '0 || m_bus_err != '0) begin
        if (cpl_q.size() == 0) begin
          n_chk++;
          $display("FAIL cpl_unexpected: rv %b wf %b err %b, none required", m_read_valid, m_write_finish, m_bus_err);
        end else begin
          ecpl = cpl_q.pop_front();
          check("cpl_vec", {m_read_valid, m_write_finish, m_bus_err}, {ecpl.rv, ecpl.wf, ecpl.be});
          check("cpl_latency", cyc - cmd_cyc, ecpl.dly);
          check("cmd_stable", stab_bad, 1'b0);
        end
        for (int i = 0; i < N; i++) begin
          if (m_read_valid[i])   rd_done[i] = 1'b1;
          if (m_write_finish[i]) wr_done[i] = 1'b1;
        end
      end
    end
  end

  // Monitor for the fixed-priority DUT.
  initial forever begin
    @(negedge clk);
    if (rst_n && fx_read_req) begin
      fx_seen++;
      if (fx_q.size() == 0) begin
        n_chk++;
        $display("FAIL fx_unexpected: grant %0d issued, none required", fx_grant);
      end else begin
        efx = fx_q.pop_front();
        check("fx_gid", fx_grant, efx);
        check("fx_route", fx_m_rv, 4'b0001);
      end
    end
  end

  // Masters drop requests after their last completion; slave answers after lat cycles unless muted.
  initial forever begin
    @(posedge clk); #1;
    if (!rst_n) begin
      rd_cnt = 0; wr_cnt = 0; read_valid = 1'b0; write_finish = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (rd_done[i]) begin
          rd_done[i] = 1'b0;
          if (rd_reps[i] > 1) rd_reps[i]--;
          else begin rd_reps[i] = 0; m_read_req[i] = 1'b0; end
        end
        if (wr_done[i]) begin
          wr_done[i] = 1'b0;
          if (wr_reps[i] > 1) wr_reps[i]--;
          else begin wr_reps[i] = 0; m_write_req[i] = 1'b0; end
        end
      end
      read_valid = 1'b0; write_finish = 1'b0;
      if (rd_cnt > 0) begin rd_cnt--; if (rd_cnt == 0) read_valid = 1'b1; end
      if (wr_cnt > 0) begin wr_cnt--; if (wr_cnt == 0) write_finish = 1'b1; end
      if (read_req)  begin if (mute > 0) mute--; else rd_cnt = lat; end
      if (write_req) begin if (mute > 0) mute--; else wr_cnt = lat; end
    end
    fx_read_valid = fx_read_req;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    bit ok;
    int seen0;
    m_read_req = '0; m_read_w = '0; m_read_hw = '0; m_read_adr = '0;
    m_write_req = '0; m_write_w = '0; m_write_hw = '0; m_write_adr = '0; m_write_data = '0;
    read_valid = 1'b0; write_finish = 1'b0;
    fx_rreq = '0; fx_zero = '0; fx_zadr = '0; fx_read_valid = 1'b0; fx_write_finish = 1'b0;
    for (int i = 0; i < N; i++) begin rd_reps[i] = 0; wr_reps[i] = 0; rd_done[i] = 0; wr_done[i] = 0; end

    // Reset state
    repeat (2) @(posedge clk); #2;
    check("rst_busy", busy, 1'b0);
    check("rst_cmd", {read_req, write_req, grant_id}, 5'b0);
    check("rst_strobes", {m_read_valid, m_write_finish, m_bus_err, tmo_flag}, 13'b0);
    check("rst_bus", {read_adr, write_adr, write_data}, 96'b0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Fixed priority: masters 0 and 2 request continuously, master 0 always wins
    for (int k = 0; k < 4; k++) fx_q.push_back(3'd0);
    fx_rreq = 4'b0101;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #2;
      if (fx_seen >= 4) begin ok = 1'b1; break; end
    end
    fx_rreq = '0;
    check("fx_four_grants", ok, 1'b1);
    repeat (3) @(posedge clk); #2;
    check("fx_count", fx_seen, 4);

    // Four simultaneous reads: grants 0,1,2,3, completion 2 cycles after each command
    for (int i = 0; i < N; i++) begin
      push_cmd(3'(i), 1'b0, 1'b1, 1'b0, 32'h1000 + 32'(4*i), 32'h0);
      push_cpl(4'(1 << i), 4'b0, 4'b0, 2);
    end
    for (int i = 0; i < N; i++) rd(i, 32'h1000 + 32'(4*i), 1'b1, 1'b0, 1);
    drain("t1_drain");

    // Masters 0 (read) and 2 (write) request continuously: 0,2,0,2,0,2
    for (int k = 0; k < 3; k++) begin
      push_cmd(3'd0, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0);
      push_cpl(4'b0001, 4'b0000, 4'b0, 2);
      push_cmd(3'd2, 1'b1, 1'b0, 1'b1, 32'h300, 32'h2222_0002);
      push_cpl(4'b0000, 4'b0100, 4'b0, 2);
    end
    rd(0, 32'h200, 1'b1, 1'b0, 3);
    wr(2, 32'h300, 32'h2222_0002, 1'b0, 1'b1, 3);
    drain("t2_drain");

    // Master 1 write and read together: write first, then read
    push_cmd(3'd1, 1'b1, 1'b1, 1'b0, 32'h100, 32'hA5A5_0001);
    push_cpl(4'b0000, 4'b0010, 4'b0, 2);
    push_cmd(3'd1, 1'b0, 1'b0, 1'b1, 32'h104, 32'h0);
    push_cpl(4'b0010, 4'b0000, 4'b0, 2);
    wr(1, 32'h100, 32'hA5A5_0001, 1'b1, 1'b0, 1);
    rd(1, 32'h104, 1'b0, 1'b1, 1);
    drain("t3_drain");

    // Completion on the exact watchdog cycle: no error, flag stays clear
    lat = 8;
    push_cmd(3'd2, 1'b0, 1'b0, 1'b0, 32'h500, 32'h0);
    push_cpl(4'b0100, 4'b0000, 4'b0000, 8);
    rd(2, 32'h500, 1'b0, 1'b0, 1);
    drain("t5_drain");
    check("t5_tmo_flag", tmo_flag, 1'b0);
    lat = 2;

    // Slave ignores master 3: abort 8 cycles after command, then master 0 served
    mute = 1;
    push_cmd(3'd3, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0);
    push_cpl(4'b1000, 4'b0000, 4'b1000, 8);
    push_cmd(3'd0, 1'b0, 1'b1, 1'b0, 32'h400, 32'h0);
    push_cpl(4'b0001, 4'b0000, 4'b0000, 2);
    rd(3, 32'h300, 1'b1, 1'b0, 1);
    rd(0, 32'h400, 1'b1, 1'b0, 1);
    drain("t4_drain");
    check("t4_tmo_flag", tmo_flag, 1'b1);

    // Reset during WAIT: everything clears, master 1 re-issued from pointer 0
    mute = 1;
    push_cmd(3'd1, 1'b0, 1'b1, 1'b0, 32'h600, 32'h0);
    seen0 = cmd_seen;
    rd(1, 32'h600, 1'b1, 1'b0, 1);
    rd(3, 32'h700, 1'b1, 1'b0, 1);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #2;
      if (cmd_seen > seen0) begin ok = 1'b1; break; end
    end
    check("t6_first_cmd", ok, 1'b1);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_cmd", {read_req, grant_id, read_adr}, 36'b0);
    check("t6_rst_strobes", {m_read_valid, m_bus_err, tmo_flag}, 9'b0);
    push_cmd(3'd1, 1'b0, 1'b1, 1'b0, 32'h600, 32'h0);
    push_cpl(4'b0010, 4'b0000, 4'b0, 2);
    push_cmd(3'd3, 1'b0, 1'b1, 1'b0, 32'h700, 32'h0);
    push_cpl(4'b1000, 4'b0000, 4'b0, 2);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drain("t6_drain");
    check("t6_tmo_flag", tmo_flag, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
